// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with registered one-hot grant and grant index.
// Define ARB_TIMEOUT_EN to force release of a grant held for TIMEOUT cycles.
module rr_arbiter4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] idx_q;
  logic [3:0] gnt_q;
  logic       valid_q;
  logic       timeout_q;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       release_req;

  assign release_req = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       force_rel;

  // Normal release wins over a forced one on the same edge.
  assign force_rel = (cnt_q == 8'(TIMEOUT - 1)) && !release_req;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  // Scan ptr+1 .. ptr+4 so the last holder gets lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'b11;
      idx_q     <= 2'b11;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q <= StGrant;
            idx_q   <= pick_idx;
            gnt_q   <= 4'b0001 << pick_idx;
            valid_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        StGrant: begin
          if (release_req) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            ptr_q   <= idx_q;
          end
`ifdef ARB_TIMEOUT_EN
          else if (force_rel) begin
            state_q   <= StIdle;
            gnt_q     <= 4'b0000;
            valid_q   <= 1'b0;
            ptr_q     <= idx_q;
            timeout_q <= 1'b1;
          end else if (cnt_q != 8'hff) begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4; timeout checks are built when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  rr_arbiter4 #(
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed as {gnt, gnt_idx, gnt_valid, timeout}.
  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic v, input logic to);
    check_eq(tag, {24'd0, gnt, gnt_idx, gnt_valid, timeout}, {24'd0, g, idx, v, to});
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    expect_out("reset", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Full rotation with done pulsed per grant.
    rst = 1'b0;
    req = 4'b1111;
    step();
    expect_out("rot_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      done = 1'b1;
      step();
      expect_out("rot_gap", 4'b0000, 2'((i - 1) % 4), 1'b0, 1'b0);
      done = 1'b0;
      step();
      expect_out("rot_grant", 4'b0001 << (i % 4), 2'(i % 4), 1'b1, 1'b0);
    end
    req = 4'b0000;
    step();
    expect_out("rot_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single requester, drop, then pointer-based scan.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0100;
    step();
    expect_out("single_g2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    expect_out("single_drop", 4'b0000, 2'd2, 1'b0, 1'b0);
    step();
    expect_out("idle_hold", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b0101;
    step();
    expect_out("scan_3_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    expect_out("hold_g0", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    expect_out("done_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("scan_1_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    expect_out("drop_g2", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Client 1 granted while other request bits toggle.
    req = 4'b0010;
    step();
    expect_out("g1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      req = {k[0], 1'b0, 1'b1, ~k[0]};
      step();
      expect_out("g1_toggle", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req  = 4'b1011;
    done = 1'b1;
    step();
    expect_out("g1_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("next_g3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Reset mid-grant.
    rst = 1'b1;
    req = 4'b1000;
    step();
    expect_out("rst_mid", 4'b0000, 2'd3, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    expect_out("post_rst_g3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000;
    step();
    expect_out("g3_drop", 4'b0000, 2'd3, 1'b0, 1'b0);

    // done in idle is ignored, with and without requests.
    done = 1'b1;
    step();
    expect_out("idle_done", 4'b0000, 2'd3, 1'b0, 1'b0);
    req = 4'b0001;
    step();
    expect_out("idle_done_req", 4'b0001, 2'd0, 1'b1, 1'b0);

    // done with new requests on the same edge: release only.
    req = 4'b0011;
    step();
    expect_out("done_new_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
    step();
    expect_out("done_new_next", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    step();

    // Long hold: forced release at 16 cycles only with the timeout feature.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0001;
    step();
    expect_out("hold_start", 4'b0001, 2'd0, 1'b1, 1'b0);
    repeat (15) step();
    expect_out("hold_15", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
`ifdef ARB_TIMEOUT_EN
    expect_out("to_force", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    expect_out("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    repeat (15) step();
    expect_out("to_hold_15", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    expect_out("to_done_wins", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
`else
    expect_out("no_to_16", 4'b0001, 2'd0, 1'b1, 1'b0);
    repeat (30) step();
    expect_out("no_to_46", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
